// File: rtl/result_frame_tx_pkg.sv
// rtl/result_frame_tx_pkg.sv - shared frame-engine state encoding and default buffer depth
package result_frame_tx_pkg;

   localparam int FRAME_DEPTH = 100;

   typedef enum logic [2:0] {
      IDLE,
      COLLECT,
      LOAD,
      SEND,
      RELEASE,
      DONE
   } frame_state_t;

endpackage

// File: rtl/result_frame_tx_if.sv
// rtl/result_frame_tx_if.sv - payload-in, UART-out and status signals of the frame transmitter
interface result_frame_tx_if;

   logic       Frame_Start;
   logic [7:0] Frame_Len;
   logic [7:0] In_Data;
   logic       In_Valid;
   logic       In_Ready;
   logic [7:0] Tx_Data;
   logic       Tx_Send;
   logic       Tx_Busy;
   logic       Frame_Done;
   logic       Len_Error;
   logic       Active;

   modport slave (
      input  Frame_Start, Frame_Len, In_Data, In_Valid, Tx_Busy,
      output In_Ready, Tx_Data, Tx_Send, Frame_Done, Len_Error, Active
   );

   modport master (
      output Frame_Start, Frame_Len, In_Data, In_Valid, Tx_Busy,
      input  In_Ready, Tx_Data, Tx_Send, Frame_Done, Len_Error, Active
   );

endinterface

// File: rtl/result_frame_buf.sv
// rtl/result_frame_buf.sv - DEPTH x 8 payload store, one write port, one registered read port
module result_frame_buf
   import result_frame_tx_pkg::*;
#(
   parameter int DEPTH  = FRAME_DEPTH,
   parameter int ADDR_W = 7
) (
   input  logic              clk,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [7:0]        wr_data,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [7:0]        rd_data
);

   logic [7:0] mem [DEPTH];

   // Contents are deliberately not reset; every byte is written before it is read.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
      rd_data <= mem[rd_addr];
   end

endmodule

// File: rtl/result_frame_tx.sv
// rtl/result_frame_tx.sv - buffers one encrypted frame and streams it to the UART sender
module result_frame_tx
   import result_frame_tx_pkg::*;
#(
   parameter int DEPTH    = FRAME_DEPTH,
   parameter int ADDR_W   = 7,
   parameter bit SEND_LEN = 1'b1
) (
   input  logic             Clk_100M,
   input  logic             Reset_n,
   result_frame_tx_if.slave bus
);

   localparam int         CNT_W     = ADDR_W + 1;
   localparam logic [8:0] DEPTH_LIM = 9'(DEPTH);

   frame_state_t     state, state_nxt;
   logic [7:0]       len_q, len_nxt;
   logic [CNT_W-1:0] len_c;
   logic [CNT_W-1:0] wr_cnt, wr_cnt_nxt;
   logic [CNT_W-1:0] rd_cnt, rd_cnt_nxt;
   logic             len_sent, len_sent_nxt;
   logic             tx_send_q, tx_send_nxt;
   logic [7:0]       tx_data_q, tx_data_nxt;
   logic             len_error_q, len_error_nxt;
   logic             wr_en;
   logic             in_ready;
   logic             frame_done;
   logic [7:0]       rd_data;

   assign len_c = CNT_W'(len_q);

   // The read port is addressed with the pointer value of the coming cycle so
   // that the registered read data is already valid when LOAD samples it.
   result_frame_buf #(
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W)
   ) u_buf (
      .clk     (Clk_100M),
      .wr_en   (wr_en),
      .wr_addr (wr_cnt[ADDR_W-1:0]),
      .wr_data (bus.In_Data),
      .rd_addr (rd_cnt_nxt[ADDR_W-1:0]),
      .rd_data (rd_data)
   );

   // Next-state, counter and output decode for the collect/send sequencer.
   always_comb begin
      state_nxt     = state;
      len_nxt       = len_q;
      wr_cnt_nxt    = wr_cnt;
      rd_cnt_nxt    = rd_cnt;
      len_sent_nxt  = len_sent;
      tx_send_nxt   = tx_send_q;
      tx_data_nxt   = tx_data_q;
      len_error_nxt = len_error_q;
      wr_en         = 1'b0;
      in_ready      = 1'b0;
      frame_done    = 1'b0;

      case (state)
         IDLE: begin
            if (bus.Frame_Start) begin
               if ({1'b0, bus.Frame_Len} > DEPTH_LIM) begin
                  len_error_nxt = 1'b1;
               end else begin
                  len_nxt       = bus.Frame_Len;
                  wr_cnt_nxt    = '0;
                  rd_cnt_nxt    = '0;
                  len_sent_nxt  = 1'b0;
                  len_error_nxt = 1'b0;
                  state_nxt     = COLLECT;
               end
            end
         end

         COLLECT: begin
            if (wr_cnt < len_c) begin
               in_ready = 1'b1;
               if (bus.In_Valid) begin
                  wr_en      = 1'b1;
                  wr_cnt_nxt = wr_cnt + 1'b1;
               end
            end else begin
               state_nxt = LOAD;
            end
         end

         LOAD: begin
            if (!SEND_LEN && (len_c == '0)) begin
               state_nxt = DONE;
            end else begin
               tx_data_nxt = (SEND_LEN && !len_sent) ? len_q : rd_data;
               // A sender still busy from earlier traffic holds us here so
               // that a send request never rises on top of Busy.
               if (!bus.Tx_Busy) begin
                  tx_send_nxt = 1'b1;
                  state_nxt   = SEND;
               end
            end
         end

         SEND: begin
            if (bus.Tx_Busy) begin
               tx_send_nxt = 1'b0;
               state_nxt   = RELEASE;
            end
         end

         RELEASE: begin
            if (!bus.Tx_Busy) begin
               if (SEND_LEN && !len_sent) begin
                  len_sent_nxt = 1'b1;
                  state_nxt    = (len_c != '0) ? LOAD : DONE;
               end else begin
                  rd_cnt_nxt = rd_cnt + 1'b1;
                  state_nxt  = (rd_cnt_nxt < len_c) ? LOAD : DONE;
               end
            end
         end

         DONE: begin
            frame_done = 1'b1;
            state_nxt  = IDLE;
         end

         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // State, counters and the registered UART-side outputs.
   always_ff @(posedge Clk_100M or negedge Reset_n) begin
      if (!Reset_n) begin
         state       <= IDLE;
         len_q       <= '0;
         wr_cnt      <= '0;
         rd_cnt      <= '0;
         len_sent    <= 1'b0;
         tx_send_q   <= 1'b0;
         tx_data_q   <= '0;
         len_error_q <= 1'b0;
      end else begin
         state       <= state_nxt;
         len_q       <= len_nxt;
         wr_cnt      <= wr_cnt_nxt;
         rd_cnt      <= rd_cnt_nxt;
         len_sent    <= len_sent_nxt;
         tx_send_q   <= tx_send_nxt;
         tx_data_q   <= tx_data_nxt;
         len_error_q <= len_error_nxt;
      end
   end

   assign bus.In_Ready   = in_ready;
   assign bus.Tx_Data    = tx_data_q;
   assign bus.Tx_Send    = tx_send_q;
   assign bus.Frame_Done = frame_done;
   assign bus.Len_Error  = len_error_q;
   assign bus.Active     = (state != IDLE);

endmodule

// File: tb/tb_result_frame_tx.sv
// tb/tb_result_frame_tx.sv - directed vector bench for result_frame_tx with a UART sender model
module tb_result_frame_tx;

   typedef logic [7:0] b4_t [4];
   typedef logic [7:0] b5_t [5];

   typedef struct {
      int   len;
      b4_t  din;
      int   exp_n;
      b5_t  exp;
      logic exp_err;
   } vec_t;

   logic clk = 1'b0;
   logic Reset_n;

   always #5 clk = ~clk;

   result_frame_tx_if bus ();
   result_frame_tx_if bus2 ();

   result_frame_tx #(.DEPTH(100), .ADDR_W(7), .SEND_LEN(1'b1)) dut (
      .Clk_100M (clk),
      .Reset_n  (Reset_n),
      .bus      (bus)
   );

   result_frame_tx #(.DEPTH(100), .ADDR_W(7), .SEND_LEN(1'b0)) dut_nolen (
      .Clk_100M (clk),
      .Reset_n  (Reset_n),
      .bus      (bus2)
   );

   int         n_tests = 0;
   int         n_fail = 0;
   int         cyc = 0;
   int         fd_count = 0;
   int         fd2_count = 0;
   int         send2_count = 0;
   int         hs_viol = 0;
   int         stall_req = 0;
   int         stall_viol = 0;
   int         stall_done = 0;
   int         snd_delay = 2;
   int         snd_hold = 10;
   logic [7:0] rx_q [$];
   logic [7:0] src_q [$];
   logic [7:0] exp_q [$];
   vec_t       vecs [5];

   always @(posedge clk) cyc <= cyc + 1;

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: simulation exceeded its time limit");
      $fatal(1, "watchdog");
   end

   // UART sender model and handshake monitor; all activity on the falling edge.
   initial begin : env
      int         ph;
      int         cnt;
      logic       prev_send;
      logic       prev_busy;
      logic [7:0] prev_data;
      ph = 0; cnt = 0; prev_send = 1'b0; prev_busy = 1'b0; prev_data = 8'h00;
      bus.Tx_Busy = 1'b0;
      forever begin
         @(negedge clk);
         if (bus.Tx_Send === 1'b1 && !prev_send && prev_busy) hs_viol++;
         if (bus.Tx_Send === 1'b1 && prev_send && bus.Tx_Data !== prev_data) hs_viol++;
         if (bus.Frame_Done === 1'b1) fd_count++;
         if (bus2.Frame_Done === 1'b1) fd2_count++;
         if (bus2.Tx_Send === 1'b1) send2_count++;
         prev_send = (bus.Tx_Send === 1'b1);
         prev_data = bus.Tx_Data;
         if (!Reset_n) begin
            ph = 0;
            bus.Tx_Busy = 1'b0;
         end else begin
            case (ph)
               0: if (bus.Tx_Send === 1'b1) begin
                     rx_q.push_back(bus.Tx_Data);
                     cnt = snd_delay;
                     ph = 1;
                  end
               1: if (cnt <= 1) begin
                     bus.Tx_Busy = 1'b1;
                     cnt = snd_hold;
                     ph = 2;
                  end else cnt--;
               2: if (cnt <= 1) begin
                     bus.Tx_Busy = 1'b0;
                     ph = (stall_req > 0) ? 3 : 0;
                  end else cnt--;
               3: begin
                     if (bus.Tx_Send === 1'b1) stall_viol++;
                     bus.Tx_Busy = 1'b1;
                     cnt = stall_req;
                     stall_req = 0;
                     ph = 4;
                  end
               default: begin
                     if (bus.Tx_Send === 1'b1) stall_viol++;
                     if (cnt <= 1) begin
                        bus.Tx_Busy = 1'b0;
                        stall_done++;
                        ph = 0;
                     end else cnt--;
                  end
            endcase
         end
         prev_busy = bus.Tx_Busy;
      end
   end

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic check_stream(input string name);
      check({name, "_count"}, rx_q.size(), exp_q.size());
      for (int j = 0; j < exp_q.size() && j < rx_q.size(); j++)
         check($sformatf("%s_byte%0d", name, j), rx_q[j], exp_q[j]);
   endtask

   task automatic set_vec(input int i, input int len, input b4_t din, input int exp_n,
                          input b5_t exp, input logic exp_err);
      vecs[i].len     = len;
      vecs[i].din     = din;
      vecs[i].exp_n   = exp_n;
      vecs[i].exp     = exp;
      vecs[i].exp_err = exp_err;
   endtask

   task automatic start_frame(input logic [7:0] len);
      bus.Frame_Start = 1'b1;
      bus.Frame_Len   = len;
      tick();
      bus.Frame_Start = 1'b0;
   endtask

   task automatic feed(input bit rnd, output int last_cyc);
      int guard;
      guard = 0;
      last_cyc = cyc;
      while (src_q.size() > 0 && guard < 3000) begin
         bus.In_Data  = src_q[0];
         bus.In_Valid = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
         if (bus.In_Valid && bus.In_Ready === 1'b1) begin
            void'(src_q.pop_front());
            last_cyc = cyc;
         end
         tick();
         guard++;
      end
      bus.In_Valid = 1'b0;
   endtask

   task automatic wait_done(input int fd0, input int bound, output bit ok);
      ok = 1'b0;
      for (int k = 0; k < bound; k++) begin
         if (fd_count > fd0) begin
            ok = 1'b1;
            break;
         end
         tick();
      end
   endtask

   task automatic run_vec(input int i);
      int   fd0;
      int   last;
      bit   ok;
      logic rdy_seen;
      logic act_seen;
      rx_q.delete();
      exp_q.delete();
      fd0 = fd_count;
      start_frame(8'(vecs[i].len));
      if (vecs[i].exp_err) begin
         rdy_seen = 1'b0;
         act_seen = 1'b0;
         bus.In_Valid = 1'b1;
         bus.In_Data  = 8'hEE;
         repeat (6) begin
            rdy_seen |= bus.In_Ready;
            act_seen |= bus.Active;
            tick();
         end
         bus.In_Valid = 1'b0;
         check($sformatf("v%0d_in_ready_low", i), rdy_seen, 1'b0);
         check($sformatf("v%0d_active_low", i), act_seen, 1'b0);
      end else begin
         for (int j = 0; j < vecs[i].len; j++) src_q.push_back(vecs[i].din[j]);
         feed(1'b0, last);
         wait_done(fd0, 400, ok);
         check($sformatf("v%0d_done_seen", i), ok, 1'b1);
      end
      repeat (3) tick();
      for (int j = 0; j < vecs[i].exp_n; j++) exp_q.push_back(vecs[i].exp[j]);
      check_stream($sformatf("v%0d_stream", i));
      check($sformatf("v%0d_len_error", i), bus.Len_Error, vecs[i].exp_err);
      check($sformatf("v%0d_done_pulses", i), fd_count - fd0, vecs[i].exp_err ? 0 : 1);
      check($sformatf("v%0d_active_after", i), bus.Active, 1'b0);
   endtask

   initial begin : main
      int   fd0;
      int   k;
      int   last;
      int   sd0;
      bit   ok;
      logic sent2;

      Reset_n = 1'b0;
      bus.Frame_Start = 1'b0; bus.Frame_Len = 8'h00; bus.In_Data = 8'h00; bus.In_Valid = 1'b0;
      bus2.Frame_Start = 1'b0; bus2.Frame_Len = 8'h00; bus2.In_Data = 8'h00; bus2.In_Valid = 1'b0;
      bus2.Tx_Busy = 1'b0;

      set_vec(0, 3,   '{8'h41, 8'h42, 8'h43, 8'h00}, 4, '{8'h03, 8'h41, 8'h42, 8'h43, 8'h00}, 1'b0);
      set_vec(1, 0,   '{8'h00, 8'h00, 8'h00, 8'h00}, 1, '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 1'b0);
      set_vec(2, 101, '{8'h00, 8'h00, 8'h00, 8'h00}, 0, '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 1'b1);
      set_vec(3, 2,   '{8'hA5, 8'h5A, 8'h00, 8'h00}, 3, '{8'h02, 8'hA5, 8'h5A, 8'h00, 8'h00}, 1'b0);
      set_vec(4, 1,   '{8'hFF, 8'h00, 8'h00, 8'h00}, 2, '{8'h01, 8'hFF, 8'h00, 8'h00, 8'h00}, 1'b0);

      repeat (3) tick();
      check("rst_in_ready",   bus.In_Ready,   1'b0);
      check("rst_tx_send",    bus.Tx_Send,    1'b0);
      check("rst_tx_data",    bus.Tx_Data,    8'h00);
      check("rst_frame_done", bus.Frame_Done, 1'b0);
      check("rst_len_error",  bus.Len_Error,  1'b0);
      check("rst_active",     bus.Active,     1'b0);
      Reset_n = 1'b1;
      tick();

      for (int i = 0; i < 5; i++) run_vec(i);

      // Full-depth frame with a gappy input stream, plus the 3-cycle send latency.
      rx_q.delete(); exp_q.delete();
      fd0 = fd_count;
      exp_q.push_back(8'h64);
      for (int i = 0; i < 100; i++) begin
         src_q.push_back(8'(i * 37 + 5));
         exp_q.push_back(8'(i * 37 + 5));
      end
      start_frame(8'd100);
      feed(1'b1, last);
      check("full_all_accepted", src_q.size(), 0);
      bus.In_Valid = 1'b1;
      bus.In_Data  = 8'hDD;
      check("full_extra_in_ready", bus.In_Ready, 1'b0);
      bus.In_Valid = 1'b0;
      k = 0;
      while (bus.Tx_Send !== 1'b1 && k < 20) begin
         tick();
         k++;
      end
      check("full_send_latency", cyc - last, 3);
      wait_done(fd0, 3000, ok);
      check("full_done_seen", ok, 1'b1);
      repeat (3) tick();
      check_stream("full_stream");
      check("full_done_pulses", fd_count - fd0, 1);

      // Payload-only instance with an empty frame.
      fd0 = fd2_count;
      bus2.Frame_Start = 1'b1;
      bus2.Frame_Len   = 8'd0;
      tick();
      bus2.Frame_Start = 1'b0;
      check("nolen_active", bus2.Active, 1'b1);
      k = 0;
      while (bus2.Frame_Done !== 1'b1 && k < 20) begin
         tick();
         k++;
      end
      check("nolen_done_delay", k, 2);
      repeat (3) tick();
      check("nolen_no_send", send2_count, 0);
      check("nolen_done_pulses", fd2_count - fd0, 1);
      check("nolen_active_after", bus2.Active, 1'b0);

      // Stray Frame_Start during SEND, and Busy already high when LOAD is reached.
      rx_q.delete(); exp_q.delete();
      fd0 = fd_count;
      sd0 = stall_done;
      stall_req = 4;
      src_q.push_back(8'h10); src_q.push_back(8'h20); src_q.push_back(8'h30);
      start_frame(8'd3);
      feed(1'b0, last);
      k = 0;
      while (bus.Tx_Send !== 1'b1 && k < 50) begin
         tick();
         k++;
      end
      check("stray_send_seen", bus.Tx_Send, 1'b1);
      bus.Frame_Start = 1'b1;
      bus.Frame_Len   = 8'd1;
      tick();
      bus.Frame_Start = 1'b0;
      wait_done(fd0, 400, ok);
      check("stray_done_seen", ok, 1'b1);
      repeat (3) tick();
      exp_q.push_back(8'h03); exp_q.push_back(8'h10); exp_q.push_back(8'h20); exp_q.push_back(8'h30);
      check_stream("stray_stream");
      check("stray_done_pulses", fd_count - fd0, 1);
      check("stall_exercised", stall_done - sd0, 1);
      check("stall_no_send", stall_viol, 0);
      check("stray_active_after", bus.Active, 1'b0);

      // Reset while a byte is being offered, then a clean frame.
      rx_q.delete(); exp_q.delete();
      src_q.push_back(8'hA1); src_q.push_back(8'hB2); src_q.push_back(8'hC3);
      start_frame(8'd3);
      feed(1'b0, last);
      k = 0;
      sent2 = 1'b0;
      while (!sent2 && k < 200) begin
         sent2 = (bus.Tx_Send === 1'b1) && (rx_q.size() >= 2);
         if (!sent2) begin
            tick();
            k++;
         end
      end
      check("rst_mid_send_seen", sent2, 1'b1);
      Reset_n = 1'b0;
      #1;
      check("rst_mid_tx_send", bus.Tx_Send, 1'b0);
      check("rst_mid_active", bus.Active, 1'b0);
      tick();
      tick();
      Reset_n = 1'b1;
      tick();
      rx_q.delete();
      fd0 = fd_count;
      src_q.push_back(8'h05); src_q.push_back(8'h06);
      start_frame(8'd2);
      feed(1'b0, last);
      wait_done(fd0, 400, ok);
      check("post_rst_done_seen", ok, 1'b1);
      repeat (3) tick();
      exp_q.push_back(8'h02); exp_q.push_back(8'h05); exp_q.push_back(8'h06);
      check_stream("post_rst_stream");
      check("post_rst_done_pulses", fd_count - fd0, 1);

      check("handshake_rules", hs_viol, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/result_frame_tx.md
Name: result_frame_tx

Overview:
- Downstream of the XOR encryption stage. Collects the encrypted result bytes of one frame into a local buffer.
- Once the frame is complete, it streams the frame to UART_Sender: an optional length byte first, then the payload bytes in index order.
- It replaces the ad-hoc Tx_DataIndex/lock logic in the top level with a clean Send/Busy handshake engine.

Parameters:
- DEPTH, 100, payload buffer capacity in bytes (matches the userData/result arrays).
- ADDR_W, 7, buffer index width; must satisfy 2^ADDR_W >= DEPTH.
- SEND_LEN, 1, 1 = prefix the frame with the length byte; 0 = payload only.

Ports:
- Clk_100M  in  1  system clock.
- Reset_n  in  1  asynchronous, active-low reset.
- Frame_Start  in  1  one-cycle pulse; latches Frame_Len and opens a new frame.
- Frame_Len  in  8  payload byte count, sampled on Frame_Start.
- In_Data  in  8  encrypted byte from the encryption stage.
- In_Valid  in  1  In_Data is valid.
- In_Ready  out  1  block accepts In_Data this cycle.
- Tx_Data  out  8  byte to UART_Sender.
- Tx_Send  out  1  send request to UART_Sender.
- Tx_Busy  in  1  UART_Sender busy flag.
- Frame_Done  out  1  one-cycle pulse after the last byte's Tx_Busy falls.
- Len_Error  out  1  sticky; set when Frame_Len > DEPTH, cleared by the next valid Frame_Start.
- Active  out  1  high in any state other than IDLE.

Behaviour:
- Reset (async assert, sync release):
  - State goes to IDLE.
  - In_Ready, Tx_Send, Frame_Done, Len_Error and Active all 0.
  - Tx_Data = 8'h00; write and read counters = 0.
  - Buffer contents are not reset.
- States: IDLE, COLLECT, LOAD, SEND, RELEASE, DONE.
- IDLE:
  - On Frame_Start with Frame_Len <= DEPTH: latch len, clear counters, clear Len_Error, go to COLLECT.
  - On Frame_Start with Frame_Len > DEPTH: set Len_Error, stay in IDLE, emit nothing.
- COLLECT:
  - In_Ready = 1 while wr_cnt < len.
  - Each In_Valid & In_Ready cycle writes buf[wr_cnt] and increments wr_cnt.
  - When wr_cnt reaches len (checked the cycle after the final write), go to LOAD.
  - len = 0 goes to LOAD immediately.
- LOAD (one cycle):
  - Tx_Data <= length byte if SEND_LEN and the length has not yet been sent.
  - Otherwise Tx_Data <= buf[rd_cnt].
  - If nothing remains to send (SEND_LEN=0 and len=0), go to DONE instead.
- SEND:
  - Tx_Send = 1; Tx_Data held stable.
  - On the first cycle Tx_Busy = 1: Tx_Send <= 0, go to RELEASE.
- RELEASE:
  - Wait for Tx_Busy = 0.
  - Then advance the pointer: mark the length byte sent, or rd_cnt++.
  - If bytes remain, go to LOAD; else go to DONE.
- DONE: Frame_Done = 1 for one cycle, then go to IDLE.
- Handshake rules:
  - Tx_Send never rises while Tx_Busy = 1.
  - Tx_Data never changes while Tx_Send = 1.
  - Exactly one UART byte per SEND→RELEASE pair.
- Frame_Start outside IDLE is ignored; len is not re-sampled.
- In_Valid outside COLLECT, or after wr_cnt = len, is ignored: In_Ready = 0 and nothing is written.
- Length byte value is the latched len (8 bits, unmodified).
- Counters are ADDR_W+1 bits wide; no wrap occurs because len <= DEPTH.
- Reset mid-frame: Tx_Send drops asynchronously; the partial frame is discarded and never resumed.
- Latency (SEND_LEN=1, ideal sender): from the last accepted payload byte to Tx_Send rising = 3 cycles (COLLECT exit, LOAD, SEND).

Decomposition:
- Shared package: state encoding enum (IDLE..DONE) and the DEPTH default constant (100), also used by the receiver-side deframer.
- One sub-module is natural: result_frame_buf, a DEPTH x 8 single-write/single-read register array with registered read.
- The FSM and counters stay in result_frame_tx.

Test Plan:
- Frame_Len=3, SEND_LEN=1, bytes 0x41,0x42,0x43; sender model raises Busy 2 cycles after Send and holds it 10 cycles -> UART bytes 0x03,0x41,0x42,0x43, one Frame_Done pulse, Active low afterwards.
- Frame_Len=0, SEND_LEN=1 -> single byte 0x00, then Frame_Done. With SEND_LEN=0 -> no Tx_Send, Frame_Done 2 cycles after Frame_Start.
- Frame_Len=101 -> Len_Error=1, no Tx_Send, In_Ready stays 0. Then Frame_Len=2 -> Len_Error clears and the frame sends normally.
- Frame_Len=100, In_Valid toggling randomly -> exactly 100 bytes accepted; 101st In_Valid sees In_Ready=0; UART stream is 0x64 followed by the bytes in order.
- Frame_Start pulsed during SEND, and Tx_Busy already high when LOAD completes -> second start ignored; Tx_Send waits for Busy low, then a fresh Busy cycle; no duplicated or skipped byte.
- Reset_n asserted while Tx_Send=1 mid-frame -> Tx_Send=0 in the same cycle, state IDLE; a new frame of 0x05,0x06 afterwards transmits 0x02,0x05,0x06.
